// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver: PS/2 deserialiser folding E0/F0 prefixes into single make/break key events
module ps2_scan_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  input  logic       kbd_dat,
  output logic       make,
  output logic       breakk,
  output logic [8:0] key_code,
  output logic       frame_err
);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state;
  logic [1:0] clk_s, dat_s;
  logic filt, fe, par, ext, brk;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] tcnt;
  logic [2:0] cnt;
  logic [7:0] sh;
  logic flip, good, ign, tout;
  assign flip = (clk_s[1] != filt) && fcnt == FW'(FILTER_LEN - 1);
  assign good = (^{sh, par}) & dat_s[1];
  assign ign  = sh inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
  assign tout = state != IDLE && !fe && tcnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
      filt <= 1'b1;
      fcnt <= '0;
      fe <= 1'b0;
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      par <= 1'b0;
      tcnt <= '0;
      ext <= 1'b0;
      brk <= 1'b0;
      make <= 1'b0;
      breakk <= 1'b0;
      frame_err <= 1'b0;
      key_code <= '0;
    end else begin
      clk_s <= {clk_s[0], in};
      dat_s <= {dat_s[0], kbd_dat};
      fcnt <= (clk_s[1] != filt && !flip) ? fcnt + 1'b1 : '0;
      if (flip) filt <= clk_s[1];
      fe <= flip & ~clk_s[1];
      make <= 1'b0;
      breakk <= 1'b0;
      frame_err <= 1'b0;
      tcnt <= state == IDLE ? '0 : fe ? TW'(1) : tcnt + 1'b1;
      if (tout) begin
        state <= IDLE;
        frame_err <= 1'b1;
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (fe) begin
        case (state)
          IDLE: if (!dat_s[1]) begin
            state <= DATA;
            cnt <= '0;
          end
          DATA: begin
            sh <= {dat_s[1], sh[7:1]};
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par <= dat_s[1];
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!good) begin
              frame_err <= 1'b1;
              ext <= 1'b0;
              brk <= 1'b0;
            end else if (sh == 8'hE0) ext <= 1'b1;
            else if (sh == 8'hF0) brk <= 1'b1;
            else if (!ign) begin
              key_code <= {ext, sh};
              make <= ~brk;
              breakk <= brk;
              ext <= 1'b0;
              brk <= 1'b0;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ps2_scan_receiver.sv
// tb_ps2_scan_receiver: directed self-checking bench for ps2_scan_receiver
module tb_ps2_scan_receiver;
  localparam int FL = 4;
  localparam int TO = 100;
  localparam int H  = 10;
  logic clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_dat = 1'b1;
  logic make, breakk, frame_err;
  logic [8:0] key_code, last_code;
  int n_cmp = 0, n_bad = 0;
  int n_make = 0, n_break = 0, n_err = 0, n_viol = 0;
  bit prev = 0;
  time t_fall, t_stop, t_make, t_err;
  ps2_scan_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .in(ps2_clk), .kbd_dat(ps2_dat),
    .make(make), .breakk(breakk), .key_code(key_code), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (make) begin n_make++; t_make = $time; last_code = key_code; end
    if (breakk) begin n_break++; last_code = key_code; end
    if (frame_err) begin n_err++; t_err = $time; end
    if (make && breakk) n_viol++;
    if ((make | breakk | frame_err) && prev) n_viol++;
    prev = make | breakk | frame_err;
  end
  task automatic clr();
    @(posedge clk);
    n_make = 0; n_break = 0; n_err = 0;
    @(negedge clk);
  endtask
  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    t_fall = $time;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
  endtask
  task automatic send_byte(input logic [7:0] b, input logic bad);
    logic [10:0] bits;
    bits = {1'b1, ~^b ^ bad, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(bits[i]);
    t_stop = t_fall;
    repeat (20) @(negedge clk);
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (make !== 1'b0) begin n_bad++; $display("FAIL reset_make got %b want 0", make); end
    n_cmp++; if (breakk !== 1'b0) begin n_bad++; $display("FAIL reset_breakk got %b want 0", breakk); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    n_cmp++; if (key_code !== 9'h000) begin n_bad++; $display("FAIL reset_key_code got %h want 000", key_code); end
  endtask
  task automatic test_make();
    clr();
    send_byte(8'h70, 1'b0);
    n_cmp++; if (n_make !== 1) begin n_bad++; $display("FAIL make70_count got %0d want 1", n_make); end
    n_cmp++; if (n_break !== 0 || n_err !== 0) begin n_bad++; $display("FAIL make70_other got brk=%0d err=%0d want 0 0", n_break, n_err); end
    n_cmp++; if (last_code !== 9'h070) begin n_bad++; $display("FAIL make70_code got %h want 070", last_code); end
    n_cmp++; if (t_make - t_stop !== (FL + 3) * 10) begin n_bad++; $display("FAIL make70_latency got %0t want %0d", t_make - t_stop, (FL + 3) * 10); end
  endtask
  task automatic test_break();
    clr();
    send_byte(8'hF0, 1'b0);
    n_cmp++; if (n_make + n_break + n_err !== 0) begin n_bad++; $display("FAIL f0_silent got %0d events want 0", n_make + n_break + n_err); end
    send_byte(8'h70, 1'b0);
    n_cmp++; if (n_break !== 1 || n_make !== 0) begin n_bad++; $display("FAIL break70 got brk=%0d make=%0d want 1 0", n_break, n_make); end
    n_cmp++; if (last_code !== 9'h070) begin n_bad++; $display("FAIL break70_code got %h want 070", last_code); end
    send_byte(8'h69, 1'b0);
    n_cmp++; if (n_make !== 1 || n_break !== 1) begin n_bad++; $display("FAIL make69 got make=%0d brk=%0d want 1 1", n_make, n_break); end
    n_cmp++; if (last_code !== 9'h069) begin n_bad++; $display("FAIL make69_code got %h want 069", last_code); end
  endtask
  task automatic test_extended();
    clr();
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    n_cmp++; if (n_make !== 1 || n_break !== 0) begin n_bad++; $display("FAIL ext_make got make=%0d brk=%0d want 1 0", n_make, n_break); end
    n_cmp++; if (last_code !== 9'h175) begin n_bad++; $display("FAIL ext_make_code got %h want 175", last_code); end
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    n_cmp++; if (n_break !== 1 || n_make !== 1) begin n_bad++; $display("FAIL e0f0_break got brk=%0d make=%0d want 1 1", n_break, n_make); end
    n_cmp++; if (last_code !== 9'h175) begin n_bad++; $display("FAIL e0f0_code got %h want 175", last_code); end
    send_byte(8'hF0, 1'b0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    n_cmp++; if (n_break !== 2 || n_make !== 1) begin n_bad++; $display("FAIL f0e0_break got brk=%0d make=%0d want 2 1", n_break, n_make); end
    n_cmp++; if (key_code !== 9'h175) begin n_bad++; $display("FAIL f0e0_code got %h want 175", key_code); end
    send_byte(8'hFA, 1'b0);
    n_cmp++; if (n_make + n_break + n_err !== 3) begin n_bad++; $display("FAIL ignored_fa got %0d events want 3", n_make + n_break + n_err); end
  endtask
  task automatic test_parity();
    clr();
    send_byte(8'h72, 1'b1);
    n_cmp++; if (n_err !== 1 || n_make !== 0) begin n_bad++; $display("FAIL parity_err got err=%0d make=%0d want 1 0", n_err, n_make); end
    n_cmp++; if (key_code !== 9'h175) begin n_bad++; $display("FAIL parity_hold got %h want 175", key_code); end
    n_cmp++; if (t_err - t_stop !== (FL + 3) * 10) begin n_bad++; $display("FAIL parity_latency got %0t want %0d", t_err - t_stop, (FL + 3) * 10); end
    send_byte(8'hF0, 1'b0);
    send_byte(8'h72, 1'b1);
    send_byte(8'h72, 1'b0);
    n_cmp++; if (n_make !== 1 || n_break !== 0) begin n_bad++; $display("FAIL err_clears_brk got make=%0d brk=%0d want 1 0", n_make, n_break); end
    n_cmp++; if (last_code !== 9'h072) begin n_bad++; $display("FAIL err_clears_brk_code got %h want 072", last_code); end
  endtask
  task automatic test_timeout();
    logic [5:0] bits;
    clr();
    bits = 6'b111010;
    for (int i = 0; i < 6; i++) ps2_bit(bits[i]);
    for (int i = 0; i < 3 * TO && n_err == 0; i++) @(negedge clk);
    n_cmp++; if (n_err !== 1) begin n_bad++; $display("FAIL timeout_err got %0d want 1", n_err); end
    n_cmp++; if (t_err - t_fall !== (TO + FL + 2) * 10) begin n_bad++; $display("FAIL timeout_latency got %0t want %0d", t_err - t_fall, (TO + FL + 2) * 10); end
    send_byte(8'h7D, 1'b0);
    n_cmp++; if (n_make !== 1 || last_code !== 9'h07D) begin n_bad++; $display("FAIL after_timeout got make=%0d code=%h want 1 07d", n_make, last_code); end
  endtask
  task automatic test_glitch();
    clr();
    ps2_dat = 1'b0;
    for (int g = 0; g < 5; g++) begin
      ps2_clk = 1'b0;
      repeat (FL - 1) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (8) @(negedge clk);
    end
    ps2_dat = 1'b1;
    repeat (2 * TO) @(negedge clk);
    n_cmp++; if (n_err !== 0) begin n_bad++; $display("FAIL glitch_err got %0d want 0", n_err); end
    send_byte(8'h74, 1'b0);
    n_cmp++; if (n_make !== 1 || n_err !== 0 || last_code !== 9'h074) begin n_bad++; $display("FAIL glitch_frame got make=%0d err=%0d code=%h want 1 0 074", n_make, n_err, last_code); end
  endtask
  task automatic test_reset_mid_frame();
    logic [4:0] bits;
    clr();
    bits = 5'b10110;
    for (int i = 0; i < 5; i++) ps2_bit(bits[i]);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (key_code !== 9'h000 || make !== 1'b0 || breakk !== 1'b0 || frame_err !== 1'b0) begin n_bad++; $display("FAIL midreset_outputs got code=%h m=%b b=%b e=%b want 000 0 0 0", key_code, make, breakk, frame_err); end
    repeat (2 * TO) @(negedge clk);
    n_cmp++; if (n_err !== 0) begin n_bad++; $display("FAIL midreset_silent got %0d want 0", n_err); end
    send_byte(8'h6B, 1'b0);
    n_cmp++; if (n_make !== 1 || last_code !== 9'h06B) begin n_bad++; $display("FAIL midreset_6b got make=%0d code=%h want 1 06b", n_make, last_code); end
  endtask
  initial begin
    test_reset();
    test_make();
    test_break();
    test_extended();
    test_parity();
    test_timeout();
    test_glitch();
    test_reset_mid_frame();
    n_cmp++; if (n_viol !== 0) begin n_bad++; $display("FAIL strobe_invariants got %0d violations want 0", n_viol); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
